// File: rtl/data_memory.sv
// Data-side memory for the pipelined MIPS core: combinational extending loads,
// byte/halfword-merging synchronous stores, and a registered store log for the auto-judge.
module data_memory #(
   parameter int          WORDS_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic        re,
   input  logic [2:0]  op,
   output logic [31:0] rdata,
   output logic        fault,
   output logic        log_valid,
   output logic [31:0] log_pc,
   output logic [31:0] log_addr,
   output logic [31:0] log_data
);

   localparam int WORDS = 1 << WORDS_LOG2;

   logic [31:0]           mem_q [WORDS];
   logic                  log_valid_q, log_valid_d;
   logic [31:0]           log_pc_q, log_pc_d;
   logic [31:0]           log_addr_q, log_addr_d;
   logic [31:0]           log_data_q, log_data_d;

   logic [31:0]           off;
   logic [WORDS_LOG2-1:0] word_idx;
   logic                  out_of_range;
   logic                  misaligned;
   logic                  reserved;
   logic                  commit;
   logic [31:0]           old_word;
   logic [31:0]           merged_word;
   logic [15:0]           half_lane;
   logic [7:0]            byte_lane;

   always_comb begin
      off          = addr - BASE_ADDR;
      word_idx     = off[WORDS_LOG2+1:2];
      // 33-bit compare so the range limit cannot wrap for large WORDS_LOG2
      out_of_range = ({1'b0, off} >= (33'd4 << WORDS_LOG2));
      reserved     = (op > 3'd4);
      misaligned   = 1'b0;
      case (op)
         3'd0:       misaligned = (addr[1:0] != 2'b00);
         3'd1, 3'd2: misaligned = addr[0];
         default:    misaligned = 1'b0;
      endcase
      fault = (we | re) & (misaligned | out_of_range | reserved);

      old_word  = mem_q[word_idx];
      half_lane = old_word[{addr[1], 4'b0000} +: 16];
      byte_lane = old_word[{addr[1:0], 3'b000} +: 8];

      rdata = 32'h0;
      if (re && !fault) begin
         case (op)
            3'd0:    rdata = old_word;
            3'd1:    rdata = {{16{half_lane[15]}}, half_lane};
            3'd2:    rdata = {16'h0, half_lane};
            3'd3:    rdata = {{24{byte_lane[7]}}, byte_lane};
            3'd4:    rdata = {24'h0, byte_lane};
            default: rdata = 32'h0;
         endcase
      end

      merged_word = old_word;
      case (op)
         3'd0:       merged_word = wdata;
         3'd1, 3'd2: merged_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
         3'd3, 3'd4: merged_word[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
         default:    merged_word = old_word;
      endcase

      commit      = we & ~fault;
      log_valid_d = commit;
      log_pc_d    = commit ? pc : log_pc_q;
      log_addr_d  = commit ? {addr[31:2], 2'b00} : log_addr_q;
      log_data_d  = commit ? merged_word : log_data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WORDS; i++) mem_q[i] <= 32'h0;
         log_valid_q <= 1'b0;
         log_pc_q    <= 32'h0;
         log_addr_q  <= 32'h0;
         log_data_q  <= 32'h0;
      end else begin
         if (commit) mem_q[word_idx] <= merged_word;
         log_valid_q <= log_valid_d;
         log_pc_q    <= log_pc_d;
         log_addr_q  <= log_addr_d;
         log_data_q  <= log_data_d;
      end
   end

   assign log_valid = log_valid_q;
   assign log_pc    = log_pc_q;
   assign log_addr  = log_addr_q;
   assign log_data  = log_data_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: byte-array reference model checked every cycle, plus directed
// literal checks for the store/load/fault/reset scenarios.
module tb_data_memory;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc, addr, wdata;
   logic        we, re;
   logic [2:0]  op;
   logic [31:0] rdata;
   logic        fault;
   logic        log_valid;
   logic [31:0] log_pc, log_addr, log_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_memory #(.WORDS_LOG2(10), .BASE_ADDR(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .pc(pc), .addr(addr), .wdata(wdata),
      .we(we), .re(re), .op(op), .rdata(rdata), .fault(fault),
      .log_valid(log_valid), .log_pc(log_pc), .log_addr(log_addr), .log_data(log_data)
   );

   // ---------------- reference model: 4 KiB byte array ----------------
   logic [7:0]  mb [4096];
   logic        model_ok = 1'b0;
   logic        exp_lv;
   logic [31:0] exp_lpc, exp_laddr;
   logic [31:0] exp_q[$];

   function automatic int acc_size(input logic [2:0] o);
      case (o)
         3'd0:       return 4;
         3'd1, 3'd2: return 2;
         3'd3, 3'd4: return 1;
         default:    return 0;
      endcase
   endfunction

   function automatic logic m_fault(input logic w, input logic r, input logic [2:0] o,
                                    input logic [31:0] a);
      int sz;
      if (!(w || r)) return 1'b0;
      if (o > 3'd4) return 1'b1;
      if (a >= 32'd4096) return 1'b1;
      sz = acc_size(o);
      if ((a % sz) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_load(input logic r, input logic [2:0] o,
                                          input logic [31:0] a, input logic f);
      logic [31:0] v;
      int sz;
      if (!r || f) return 32'h0;
      sz = acc_size(o);
      v = 32'h0;
      for (int i = 0; i < sz; i++) v = v | (32'(mb[a + i]) << (8 * i));
      if (o == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      if (o == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
      return v;
   endfunction

   function automatic logic [31:0] m_word(input logic [31:0] a);
      logic [31:0] base;
      base = a & 32'hFFFF_FFFC;
      return {mb[base + 3], mb[base + 2], mb[base + 1], mb[base]};
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
         exp_lv    = 1'b0;
         exp_lpc   = 32'h0;
         exp_laddr = 32'h0;
         exp_q.delete();
         model_ok  = 1'b1;
      end else begin
         exp_lv = 1'b0;
         if (model_ok && we && !m_fault(we, re, op, addr)) begin
            for (int i = 0; i < acc_size(op); i++) mb[addr + i] = wdata[8*i +: 8];
            exp_lv    = 1'b1;
            exp_lpc   = pc;
            exp_laddr = addr & 32'hFFFF_FFFC;
            exp_q.push_back(m_word(addr));
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_ok) begin
         logic f;
         f = m_fault(we, re, op, addr);
         chk("fault", 32'(fault), 32'(f));
         chk("rdata", rdata, m_load(re, op, addr, f));
         chk("log_valid", 32'(log_valid), 32'(exp_lv));
         if (exp_lv) begin
            chk("log_pc", log_pc, exp_lpc);
            chk("log_addr", log_addr, exp_laddr);
         end
         if (log_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("log_q_empty", 32'h1, 32'h0);
            else chk("log_data", log_data, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply(input logic w, input logic r, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
      we = w; re = r; op = o; addr = a; wdata = d; pc = p;
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; we = 1'b0; re = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0; pc = 32'h0;
      adv(); adv();
      reset = 1'b0;

      apply(0, 1, 3'd0, 32'h40, 0, 0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_log_valid", 32'(log_valid), 32'h0);
      chk("rst_log_pc", log_pc, 32'h0);
      chk("rst_log_addr", log_addr, 32'h0);
      chk("rst_log_data", log_data, 32'h0);
      adv();

      // word store and log
      apply(1, 0, 3'd0, 32'h10, 32'h8765_4321, 32'h3000); adv();
      apply(0, 1, 3'd0, 32'h10, 0, 0);
      chk("lw_after_sw", rdata, 32'h8765_4321);
      chk("sw_log_valid", 32'(log_valid), 32'h1);
      chk("sw_log_pc", log_pc, 32'h3000);
      chk("sw_log_addr", log_addr, 32'h10);
      chk("sw_log_data", log_data, 32'h8765_4321);
      adv();
      apply(0, 0, 3'd0, 32'h0, 0, 0);
      chk("log_pulse_end", 32'(log_valid), 32'h0);
      adv();

      // partial stores and extending loads
      apply(1, 0, 3'd3, 32'h11, 32'h0000_00AA, 32'h3004); adv();
      apply(0, 1, 3'd0, 32'h10, 0, 0); chk("sb_merge", rdata, 32'h8765_AA21); adv();
      apply(0, 1, 3'd3, 32'h11, 0, 0); chk("lb", rdata, 32'hFFFF_FFAA); adv();
      apply(0, 1, 3'd4, 32'h11, 0, 0); chk("lbu", rdata, 32'h0000_00AA); adv();
      apply(1, 0, 3'd1, 32'h12, 32'h0000_8001, 32'h3008); adv();
      apply(0, 1, 3'd0, 32'h10, 0, 0); chk("sh_merge", rdata, 32'h8001_AA21); adv();
      apply(0, 1, 3'd1, 32'h12, 0, 0); chk("lh", rdata, 32'hFFFF_8001); adv();
      apply(0, 1, 3'd2, 32'h12, 0, 0); chk("lhu", rdata, 32'h0000_8001); adv();

      // faults
      apply(1, 0, 3'd0, 32'h13, 32'hFFFF_FFFF, 32'h300C); chk("sw_mis_fault", 32'(fault), 32'h1); adv();
      apply(0, 1, 3'd0, 32'h10, 0, 0);
      chk("sw_mis_nowrite", rdata, 32'h8001_AA21);
      chk("sw_mis_nolog", 32'(log_valid), 32'h0);
      adv();
      apply(0, 1, 3'd1, 32'h11, 0, 0);
      chk("lh_mis_fault", 32'(fault), 32'h1); chk("lh_mis_rdata", rdata, 32'h0); adv();
      apply(0, 1, 3'd0, 32'h1000, 0, 0);
      chk("oor_fault", 32'(fault), 32'h1); chk("oor_rdata", rdata, 32'h0); adv();
      apply(0, 1, 3'd6, 32'h10, 0, 0);
      chk("resv_fault", 32'(fault), 32'h1); chk("resv_rdata", rdata, 32'h0); adv();

      // same-cycle read/write
      apply(1, 0, 3'd0, 32'h20, 32'h1111_1111, 32'h3010); adv();
      apply(1, 1, 3'd0, 32'h20, 32'h2222_2222, 32'h3014); chk("rw_old", rdata, 32'h1111_1111); adv();
      apply(0, 1, 3'd0, 32'h20, 0, 0); chk("rw_new", rdata, 32'h2222_2222); adv();

      // reset versus store
      reset = 1'b1;
      apply(1, 0, 3'd0, 32'h40, 32'hDEAD_BEEF, 32'h3018); adv();
      reset = 1'b0;
      apply(0, 1, 3'd0, 32'h40, 0, 0);
      chk("rst_store_lost", rdata, 32'h0); chk("rst_store_nolog", 32'(log_valid), 32'h0); adv();
      apply(1, 0, 3'd0, 32'h40, 32'h5, 32'h301C); adv();
      reset = 1'b1;
      apply(0, 0, 3'd0, 32'h0, 0, 0); adv();
      reset = 1'b0;
      apply(0, 1, 3'd0, 32'h40, 0, 0); chk("rst_clears", rdata, 32'h0); adv();

      // back-to-back stores
      apply(1, 0, 3'd0, 32'h0, 32'hA0A0_0000, 32'h3020); adv();
      apply(1, 0, 3'd0, 32'h4, 32'hA0A0_0004, 32'h3024); chk("b2b_addr0", log_addr, 32'h0); adv();
      apply(1, 0, 3'd0, 32'h8, 32'hA0A0_0008, 32'h3028); chk("b2b_addr4", log_addr, 32'h4); adv();
      apply(0, 0, 3'd0, 32'h0, 0, 0);
      chk("b2b_valid8", 32'(log_valid), 32'h1); chk("b2b_addr8", log_addr, 32'h8); adv();
      apply(0, 0, 3'd0, 32'h0, 0, 0); chk("b2b_end", 32'(log_valid), 32'h0); adv();

      // randomized traffic concentrated on a small window to force collisions
      for (int n = 0; n < 3000; n++) begin
         logic [2:0]  o;
         logic [31:0] a;
         o = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
         reset = ($urandom_range(0, 199) == 0);
         apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o, a, $urandom, $urandom);
         adv();
      end
      reset = 1'b0;
      apply(0, 0, 3'd0, 32'h0, 0, 0);
      adv();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
